// File: rtl/tdc_evt_pkg.sv
// Shared types and constants for the TDC event buffer: event record, FSM encoding
// and a saturating counter helper.
package tdc_evt_pkg;

  localparam int SEQ_W = 16;
  localparam logic [15:0] CNT_SAT = 16'hFFFF;
  localparam int TDC_TS_W = 32;
  localparam int TDC_TOT_W = 32;

  typedef struct packed {
    logic [SEQ_W-1:0]     seq;
    logic [TDC_TS_W-1:0]  ts;
    logic [TDC_TOT_W-1:0] tot;
  } tdc_evt_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    WAIT_LOW = 2'd2
  } tdc_buf_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tdc_evt_fifo.sv
// First-word-fall-through FIFO of tdc_evt_t records; head data reads as zero
// while empty. Push while full is accepted only if a pop happens at the same edge.
module tdc_evt_fifo
  import tdc_evt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  tdc_evt_t                 push_data,
  input  logic                     pop,
  input  logic                     flush,
  output tdc_evt_t                 pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  tdc_evt_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(DEPTH));

  // A flush overrides both sides of the handshake at its edge.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/tdc_event_buffer.sv
// Captures completed TDC measurements into a sequence-tagged FWFT FIFO and re-arms
// the channel. Define TDC_TOT_FILTER_EN to drop short pulses (MIN_TOT, o_filtered_cnt).
module tdc_event_buffer
  import tdc_evt_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 32,
  parameter int TOT_W = 32
`ifdef TDC_TOT_FILTER_EN
  , parameter int unsigned MIN_TOT = 4
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_capture_en,
  input  logic                     i_flush,
  input  logic                     i_tdc_hasEvent,
  input  logic [TS_W-1:0]          i_tdc_timestamp,
  input  logic [TOT_W-1:0]         i_tdc_pulseWidth,
  output logic                     o_tdc_clear,
  output logic                     o_evt_valid,
  input  logic                     i_evt_ready,
  output logic [15:0]              o_evt_seq,
  output logic [TS_W-1:0]          o_evt_ts,
  output logic [TOT_W-1:0]         o_evt_tot,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [15:0]              o_overflow_cnt
`ifdef TDC_TOT_FILTER_EN
  , output logic [15:0]            o_filtered_cnt
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'(IDLE);
  localparam logic [1:0] ST_CLEAR    = 2'(CLEAR);
  localparam logic [1:0] ST_WAIT_LOW = 2'(WAIT_LOW);

  logic [1:0]       state;
  logic [SEQ_W-1:0] seq;
  logic             evt_start;
  logic             keep;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  tdc_evt_t         wr_evt;
  tdc_evt_t         head;

  assign evt_start = (state == ST_IDLE) && i_tdc_hasEvent;

`ifdef TDC_TOT_FILTER_EN
  logic is_short;
  assign is_short = (i_tdc_pulseWidth < TOT_W'(MIN_TOT));
  assign keep     = evt_start && i_capture_en && !is_short;
`else
  assign keep     = evt_start && i_capture_en;
`endif

  assign pop    = !fifo_empty && i_evt_ready;
  assign push   = keep && !i_flush;
  assign wr_evt = '{seq: seq,
                    ts:  TDC_TS_W'(i_tdc_timestamp),
                    tot: TDC_TOT_W'(i_tdc_pulseWidth)};

  tdc_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wr_evt),
    .pop       (pop),
    .flush     (i_flush),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_count)
  );

  // WAIT_LOW holds off re-capture until the TDC has visibly dropped hasEvent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      o_tdc_clear <= 1'b0;
    end else begin
      o_tdc_clear <= evt_start;
      case (state)
        ST_IDLE:     if (i_tdc_hasEvent) state <= ST_CLEAR;
        ST_CLEAR:    state <= ST_WAIT_LOW;
        ST_WAIT_LOW: if (!i_tdc_hasEvent) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Dropped events still consume a sequence number so the consumer can see gaps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq            <= '0;
      o_overflow_cnt <= '0;
    end else if (keep) begin
      seq <= seq + 1'b1;
      if (!i_flush && fifo_full && !pop) begin
        o_overflow_cnt <= sat_inc(o_overflow_cnt);
      end
    end
  end

`ifdef TDC_TOT_FILTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_filtered_cnt <= '0;
    end else if (evt_start && is_short) begin
      o_filtered_cnt <= sat_inc(o_filtered_cnt);
    end
  end
`endif

  assign o_evt_valid = !fifo_empty;
  assign o_evt_seq   = head.seq;
  assign o_evt_ts    = TS_W'(head.ts);
  assign o_evt_tot   = TOT_W'(head.tot);

endmodule

// File: tb/tb_tdc_event_buffer.sv
// Directed bench for tdc_event_buffer: capture, overflow, simultaneous push/pop,
// held hasEvent, capture disable, async reset, flush and (optionally) TOT filtering.
module tb_tdc_event_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_capture_en;
  logic        i_flush;
  logic        i_tdc_hasEvent;
  logic [31:0] i_tdc_timestamp;
  logic [31:0] i_tdc_pulseWidth;
  logic        o_tdc_clear;
  logic        o_evt_valid;
  logic        i_evt_ready;
  logic [15:0] o_evt_seq;
  logic [31:0] o_evt_ts;
  logic [31:0] o_evt_tot;
  logic [3:0]  o_count;
  logic [15:0] o_overflow_cnt;
`ifdef TDC_TOT_FILTER_EN
  logic [15:0] o_filtered_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tdc_event_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .i_capture_en     (i_capture_en),
    .i_flush          (i_flush),
    .i_tdc_hasEvent   (i_tdc_hasEvent),
    .i_tdc_timestamp  (i_tdc_timestamp),
    .i_tdc_pulseWidth (i_tdc_pulseWidth),
    .o_tdc_clear      (o_tdc_clear),
    .o_evt_valid      (o_evt_valid),
    .i_evt_ready      (i_evt_ready),
    .o_evt_seq        (o_evt_seq),
    .o_evt_ts         (o_evt_ts),
    .o_evt_tot        (o_evt_tot),
    .o_count          (o_count),
    .o_overflow_cnt   (o_overflow_cnt)
`ifdef TDC_TOT_FILTER_EN
    , .o_filtered_cnt (o_filtered_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_capture_en = 1'b1;
    i_flush = 1'b0;
    i_tdc_hasEvent = 1'b0;
    i_tdc_timestamp = '0;
    i_tdc_pulseWidth = '0;
    i_evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();
  endtask

  // Emulates the TDC: hasEvent high for one edge, then low; returns clear-pulse cycles seen.
  task automatic send_event(input logic [31:0] ts, input logic [31:0] tot, output int clears);
    clears = 0;
    i_tdc_hasEvent = 1'b1;
    i_tdc_timestamp = ts;
    i_tdc_pulseWidth = tot;
    step();
    if (o_tdc_clear) clears++;
    i_tdc_hasEvent = 1'b0;
    repeat (2) begin
      step();
      if (o_tdc_clear) clears++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0h exp=0", o_evt_valid); end
    total++; if (o_tdc_clear !== 1'b0) begin bad++; $display("[TB] FAIL reset_clear got=%0h exp=0", o_tdc_clear); end
    total++; if (o_count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", o_count); end
    total++; if ({o_evt_seq, o_evt_ts, o_evt_tot} !== 80'd0) begin bad++; $display("[TB] FAIL reset_data got=%0h/%0h/%0h exp=0", o_evt_seq, o_evt_ts, o_evt_tot); end
    total++; if (o_overflow_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_ovf got=%0d exp=0", o_overflow_cnt); end
  endtask

  task automatic test_single();
    int clears;
    do_reset();
    i_tdc_hasEvent = 1'b1;
    i_tdc_timestamp = 32'h100;
    i_tdc_pulseWidth = 32'h20;
    step();
    total++; if (o_tdc_clear !== 1'b1) begin bad++; $display("[TB] FAIL single_clear_hi got=%0h exp=1", o_tdc_clear); end
    total++; if (o_evt_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%0h exp=1", o_evt_valid); end
    total++; if (o_evt_seq !== 16'd0) begin bad++; $display("[TB] FAIL single_seq got=%0d exp=0", o_evt_seq); end
    total++; if (o_evt_ts !== 32'h100) begin bad++; $display("[TB] FAIL single_ts got=%0h exp=100", o_evt_ts); end
    total++; if (o_evt_tot !== 32'h20) begin bad++; $display("[TB] FAIL single_tot got=%0h exp=20", o_evt_tot); end
    i_tdc_hasEvent = 1'b0;
    step();
    total++; if (o_tdc_clear !== 1'b0) begin bad++; $display("[TB] FAIL single_clear_lo got=%0h exp=0", o_tdc_clear); end
    step();
    i_evt_ready = 1'b1;
    step();
    i_evt_ready = 1'b0;
    total++; if (o_count !== 4'd0) begin bad++; $display("[TB] FAIL single_pop_count got=%0d exp=0", o_count); end
    total++; if (o_evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_pop_valid got=%0h exp=0", o_evt_valid); end
    // Ready held while empty must not disturb anything.
    i_evt_ready = 1'b1;
    repeat (2) step();
    i_evt_ready = 1'b0;
    send_event(32'h111, 32'h22, clears);
    total++; if (o_count !== 4'd1 || o_evt_seq !== 16'd1) begin bad++; $display("[TB] FAIL empty_ready got count=%0d seq=%0d exp count=1 seq=1", o_count, o_evt_seq); end
  endtask

  task automatic test_overflow();
    int clears;
    logic [15:0] exp_seq;
    logic [31:0] exp_ts;
    do_reset();
    for (int i = 0; i < 10; i++) send_event(32'h200 + 32'(i), 32'h40 + 32'(i), clears);
    total++; if (o_count !== 4'd8) begin bad++; $display("[TB] FAIL ovf_count got=%0d exp=8", o_count); end
    total++; if (o_overflow_cnt !== 16'd2) begin bad++; $display("[TB] FAIL ovf_cnt got=%0d exp=2", o_overflow_cnt); end
    // Capture and pop at the same edge while full.
    i_tdc_hasEvent = 1'b1;
    i_tdc_timestamp = 32'h300;
    i_tdc_pulseWidth = 32'h50;
    i_evt_ready = 1'b1;
    step();
    i_evt_ready = 1'b0;
    i_tdc_hasEvent = 1'b0;
    total++; if (o_count !== 4'd8) begin bad++; $display("[TB] FAIL full_pushpop_count got=%0d exp=8", o_count); end
    total++; if (o_overflow_cnt !== 16'd2) begin bad++; $display("[TB] FAIL full_pushpop_ovf got=%0d exp=2", o_overflow_cnt); end
    repeat (2) step();
    for (int k = 0; k < 8; k++) begin
      exp_seq = (k < 7) ? 16'(k + 1) : 16'd10;
      exp_ts  = (k < 7) ? 32'h200 + 32'(k + 1) : 32'h300;
      total++; if (o_evt_valid !== 1'b1 || o_evt_seq !== exp_seq || o_evt_ts !== exp_ts) begin
        bad++; $display("[TB] FAIL drain_%0d got v=%0h seq=%0d ts=%0h exp v=1 seq=%0d ts=%0h", k, o_evt_valid, o_evt_seq, o_evt_ts, exp_seq, exp_ts);
      end
      i_evt_ready = 1'b1;
      step();
      i_evt_ready = 1'b0;
    end
    total++; if (o_count !== 4'd0 || o_evt_ts !== 32'd0) begin bad++; $display("[TB] FAIL drain_empty got count=%0d ts=%0h exp 0/0", o_count, o_evt_ts); end
  endtask

  task automatic test_back_to_back();
    int clears;
    do_reset();
    send_event(32'hA0, 32'h5, clears);
    i_tdc_hasEvent = 1'b1;
    i_tdc_timestamp = 32'hB0;
    i_tdc_pulseWidth = 32'h6;
    i_evt_ready = 1'b1;
    step();
    i_evt_ready = 1'b0;
    i_tdc_hasEvent = 1'b0;
    total++; if (o_count !== 4'd1 || o_evt_seq !== 16'd1 || o_evt_ts !== 32'hB0) begin
      bad++; $display("[TB] FAIL b2b_count1 got count=%0d seq=%0d ts=%0h exp 1/1/b0", o_count, o_evt_seq, o_evt_ts);
    end
    repeat (2) step();
  endtask

  task automatic test_hold_high();
    int clears;
    do_reset();
    clears = 0;
    i_tdc_hasEvent = 1'b1;
    i_tdc_timestamp = 32'h400;
    i_tdc_pulseWidth = 32'h10;
    repeat (7) begin
      step();
      if (o_tdc_clear) clears++;
    end
    total++; if (clears !== 1) begin bad++; $display("[TB] FAIL hold_clears got=%0d exp=1", clears); end
    total++; if (o_count !== 4'd1) begin bad++; $display("[TB] FAIL hold_count got=%0d exp=1", o_count); end
    i_tdc_hasEvent = 1'b0;
    step();
    i_tdc_hasEvent = 1'b1;
    i_tdc_timestamp = 32'h500;
    step();
    total++; if (o_count !== 4'd2 || o_tdc_clear !== 1'b1) begin bad++; $display("[TB] FAIL hold_rearm got count=%0d clr=%0h exp 2/1", o_count, o_tdc_clear); end
    i_tdc_hasEvent = 1'b0;
    repeat (2) step();
    total++; if (o_evt_seq !== 16'd0 || o_evt_ts !== 32'h400) begin bad++; $display("[TB] FAIL hold_head0 got seq=%0d ts=%0h exp 0/400", o_evt_seq, o_evt_ts); end
    i_evt_ready = 1'b1;
    step();
    i_evt_ready = 1'b0;
    total++; if (o_evt_seq !== 16'd1 || o_evt_ts !== 32'h500) begin bad++; $display("[TB] FAIL hold_head1 got seq=%0d ts=%0h exp 1/500", o_evt_seq, o_evt_ts); end
  endtask

  task automatic test_capture_off_and_reset();
    int clears;
    int sum;
    do_reset();
    i_capture_en = 1'b0;
    sum = 0;
    for (int i = 0; i < 3; i++) begin
      send_event(32'h600 + 32'(i), 32'h9, clears);
      sum += clears;
    end
    total++; if (sum !== 3) begin bad++; $display("[TB] FAIL capoff_clears got=%0d exp=3", sum); end
    total++; if (o_count !== 4'd0) begin bad++; $display("[TB] FAIL capoff_count got=%0d exp=0", o_count); end
    i_capture_en = 1'b1;
    send_event(32'h610, 32'h9, clears);
    total++; if (o_evt_seq !== 16'd0 || o_evt_ts !== 32'h610) begin bad++; $display("[TB] FAIL capoff_seq got seq=%0d ts=%0h exp 0/610", o_evt_seq, o_evt_ts); end
    // Assert reset while the clear pulse is high.
    i_tdc_hasEvent = 1'b1;
    i_tdc_timestamp = 32'h620;
    step();
    total++; if (o_tdc_clear !== 1'b1) begin bad++; $display("[TB] FAIL midclr_pre got=%0h exp=1", o_tdc_clear); end
    #2 reset = 1'b1;
    #1;
    total++; if (o_tdc_clear !== 1'b0 || o_evt_valid !== 1'b0 || o_count !== 4'd0) begin
      bad++; $display("[TB] FAIL midclr_reset got clr=%0h v=%0h count=%0d exp 0/0/0", o_tdc_clear, o_evt_valid, o_count);
    end
    total++; if ({o_evt_seq, o_evt_ts, o_evt_tot, o_overflow_cnt} !== 96'd0) begin bad++; $display("[TB] FAIL midclr_data got %0h/%0h/%0h exp 0", o_evt_seq, o_evt_ts, o_evt_tot); end
    i_tdc_hasEvent = 1'b0;
    step();
    reset = 1'b0;
    step();
    send_event(32'h700, 32'h9, clears);
    total++; if (o_count !== 4'd1 || o_evt_seq !== 16'd0 || o_evt_ts !== 32'h700) begin
      bad++; $display("[TB] FAIL post_reset got count=%0d seq=%0d ts=%0h exp 1/0/700", o_count, o_evt_seq, o_evt_ts);
    end
  endtask

  task automatic test_flush();
    int clears;
    do_reset();
    send_event(32'h800, 32'h9, clears);
    send_event(32'h801, 32'h9, clears);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    total++; if (o_count !== 4'd0 || o_evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_empty got count=%0d v=%0h exp 0/0", o_count, o_evt_valid); end
    for (int i = 0; i < 9; i++) send_event(32'h900 + 32'(i), 32'h9, clears);
    total++; if (o_count !== 4'd8 || o_overflow_cnt !== 16'd1) begin bad++; $display("[TB] FAIL flush_fill got count=%0d ovf=%0d exp 8/1", o_count, o_overflow_cnt); end
    // Capture at a full FIFO coinciding with flush: dropped, no overflow count.
    i_tdc_hasEvent = 1'b1;
    i_tdc_timestamp = 32'hA00;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_tdc_hasEvent = 1'b0;
    total++; if (o_count !== 4'd0 || o_overflow_cnt !== 16'd1) begin bad++; $display("[TB] FAIL flush_capture got count=%0d ovf=%0d exp 0/1", o_count, o_overflow_cnt); end
    repeat (2) step();
    send_event(32'hB00, 32'h9, clears);
    total++; if (o_count !== 4'd1 || o_evt_ts !== 32'hB00) begin bad++; $display("[TB] FAIL flush_after got count=%0d ts=%0h exp 1/b00", o_count, o_evt_ts); end
  endtask

`ifdef TDC_TOT_FILTER_EN
  task automatic test_filter();
    int clears;
    do_reset();
    send_event(32'hC00, 32'd3, clears);
    total++; if (clears !== 1 || o_count !== 4'd0 || o_filtered_cnt !== 16'd1) begin
      bad++; $display("[TB] FAIL filter_short got clr=%0d count=%0d filt=%0d exp 1/0/1", clears, o_count, o_filtered_cnt);
    end
    send_event(32'hC01, 32'd4, clears);
    total++; if (o_count !== 4'd1 || o_evt_seq !== 16'd0 || o_evt_tot !== 32'd4) begin
      bad++; $display("[TB] FAIL filter_keep got count=%0d seq=%0d tot=%0d exp 1/0/4", o_count, o_evt_seq, o_evt_tot);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_hold_high();
    test_capture_off_and_reset();
    test_flush();
`ifdef TDC_TOT_FILTER_EN
    test_filter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_event_buffer.md
Name: tdc_event_buffer

Overview:
- Downstream consumer of the TDC channel (TDC_dumb).
- Detects a completed TDC measurement (o_hasEvent) and captures timestamp and pulse width into a FWFT FIFO, tagged with a 16-bit sequence number.
- Pulses the TDC's i_clear to re-arm the channel.
- Presents buffered events to the readout side through a valid/ready handshake, and counts events lost to overflow.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- TS_W, 32, timestamp width; matches TDC o_timestamp.
- TOT_W, 32, pulse-width width; matches TDC o_pulseWidth.
- MIN_TOT, 4, minimum pulse width kept; used only with TOT_FILTER_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- i_capture_en  in  1  1 = store events; 0 = clear TDC but discard.
- i_flush  in  1  synchronous FIFO flush, 1-cycle pulse.
- i_tdc_hasEvent  in  1  from TDC o_hasEvent.
- i_tdc_timestamp  in  TS_W  from TDC o_timestamp.
- i_tdc_pulseWidth  in  TOT_W  from TDC o_pulseWidth.
- o_tdc_clear  out  1  to TDC i_clear; 1-cycle pulse.
- o_evt_valid  out  1  head-of-FIFO event available.
- i_evt_ready  in  1  consumer accepts head; pop on valid & ready.
- o_evt_seq  out  16  sequence number of head event.
- o_evt_ts  out  TS_W  timestamp of head event.
- o_evt_tot  out  TOT_W  pulse width of head event.
- o_count  out  $clog2(DEPTH)+1  current occupancy.
- o_overflow_cnt  out  16  dropped-event count; saturates at 0xFFFF.

Behaviour:
Reset (async, any time, including mid-handshake):
- State = IDLE; FIFO pointers and count = 0.
- o_evt_valid = 0, o_tdc_clear = 0, seq counter = 0, o_overflow_cnt = 0.
- o_evt_* data outputs are 0 while empty.

FSM states: IDLE, CLEAR, WAIT_LOW.
- IDLE: i_tdc_hasEvent = 1 at edge N starts capture.
  - If i_capture_en = 1 and not full (or full with a pop at the same edge): write {seq, ts, tot} at edge N, then seq increments (wraps 0xFFFF -> 0).
  - If i_capture_en = 1 and full with no pop: drop the event; o_overflow_cnt += 1 (saturating); seq still increments, so gaps reveal loss.
  - If i_capture_en = 0: no write, no seq or overflow change.
  - Go to CLEAR in every case.
- CLEAR: o_tdc_clear = 1 for exactly this cycle (registered, so high from edge N to edge N+1). Then go to WAIT_LOW.
- WAIT_LOW: stay until i_tdc_hasEvent = 0 (the TDC needs >= 1 cycle to drop it), then go to IDLE. This guarantees one event is never captured twice.

FIFO (first-word-fall-through):
- o_evt_valid = (count != 0).
- Head data is valid in the cycle after the edge that wrote into an empty FIFO; write-to-valid latency is 1 cycle.
- Pop at an edge where o_evt_valid & i_evt_ready.
- Simultaneous push and pop: count unchanged; allowed when full and when count = 1.
- Pointers wrap modulo DEPTH.
- Holding i_evt_ready = 1 while empty has no effect.

i_flush:
- Empties the FIFO at the edge; pops and pushes at that same edge are ignored.
- Does not reset seq or o_overflow_cnt and does not affect the FSM.
- A capture coinciding with flush is dropped without an overflow count.

Optional Feature:
- Macro: TDC_TOT_FILTER_EN.
- Defined: in IDLE, an event with i_tdc_pulseWidth < MIN_TOT is cleared via CLEAR/WAIT_LOW but not written. It does not increment seq or o_overflow_cnt. An extra output o_filtered_cnt (16 bit, saturating, reset 0) counts these events.
- Undefined: all events are processed as above, MIN_TOT is unused, and o_filtered_cnt does not exist.

Decomposition:
- Package tdc_evt_pkg holds:
  - typedef struct packed tdc_evt_t {seq[15:0], ts[TS_W-1:0], tot[TOT_W-1:0]};
  - FSM enum tdc_buf_state_e {IDLE, CLEAR, WAIT_LOW};
  - constants SEQ_W = 16 and CNT_SAT = 16'hFFFF.
- Sub-module tdc_evt_fifo: generic FWFT synchronous FIFO of tdc_evt_t with push/pop/flush/full/empty/count. The top holds the FSM, seq counter and overflow counter.

Test Plan:
- Reset then single event: hasEvent high with ts = 0x100, tot = 0x20 at edge N -> o_tdc_clear high for exactly 1 cycle. At N+1: o_evt_valid = 1, seq = 0, ts = 0x100, tot = 0x20. Pop leaves count = 0.
- Overflow, DEPTH = 8, ready = 0: 10 events -> count = 8, o_overflow_cnt = 2. Drain yields seq 0..7; the next stored event has seq = 10.
- Push and pop in the same cycle while full -> count stays 8, overflow unchanged; output order preserved.
- hasEvent held high for 5 cycles after clear -> exactly one write; FSM stays in WAIT_LOW until hasEvent drops.
- i_capture_en = 0 with 3 events -> 3 clear pulses, count = 0, seq = 0. Assert reset mid-CLEAR -> o_tdc_clear drops immediately, all outputs 0.
- TDC_TOT_FILTER_EN, MIN_TOT = 4: tot = 3 -> cleared, not stored, o_filtered_cnt = 1. tot = 4 -> stored.
